// File: rtl/riscv_pkg.sv
// Shared fetch-stage types: fault causes, fetch FSM states and the IF/ID register layout.
package riscv_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {FC_NONE, FC_MISALIGN, FC_RANGE} fetch_fault_e;
    typedef enum logic [1:0] {F_RUN, F_HALT, F_FAULT} fetch_state_e;

    typedef struct packed {
        logic        valid;
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc_plus4;
    } if_id_t;

    // Sequential PC step; wraps modulo 2^32.
    function automatic logic [31:0] pc_inc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_pc_gen.sv
// Program counter register with next-PC selection and the misalign / out-of-range fetch checks.
module fetch_pc_gen
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_WORDS = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic        stall,
    input  logic        halt_req,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        misalign,
    output logic        range_err
);

    // Widened by one bit so a 2^30-word memory limit still compares correctly.
    localparam logic [32:0] PC_LIMIT = 33'(IMEM_WORDS) * 33'd4;

    logic [31:0] pc_p0;
    logic [31:0] pc_d;

    assign pc        = pc_p0;
    assign pc_plus4  = pc_inc(pc_p0);
    assign misalign  = redirect_valid && (redirect_target[1:0] != 2'b00);
    assign range_err = {1'b0, pc_p0} >= PC_LIMIT;

    always_comb begin
        pc_d = pc_p0;
        if (run) begin
            if (redirect_valid) begin
                if (!misalign) begin
                    pc_d = redirect_target;
                end
            end else if (!stall && !range_err && !halt_req) begin
                pc_d = pc_inc(pc_p0);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_p0 <= RESET_PC;
        end else begin
            pc_p0 <= pc_d;
        end
    end

endmodule

// File: rtl/instr_fetch_stage.sv
// Fetch stage: drives ins_mem from the PC, registers the returned word into IF/ID and
// stops on an all-zero word (halt) or an illegal fetch address (fault).
module instr_fetch_stage
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int          IMEM_WORDS   = 64,
    parameter bit          HALT_ON_ZERO = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    input  logic        id_stall,
    output logic        if_id_valid,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc_plus4,
    output logic        halted,
    output logic        fault,
    output logic [1:0]  fault_cause,
    output logic [31:0] fetch_count
);

    fetch_state_e state_q, state_d;
    fetch_fault_e cause_q, cause_d;
    if_id_t       if_id_p1, if_id_d;
    logic [31:0]  count_q, count_d;

    logic [31:0]  pc;
    logic [31:0]  pc_plus4;
    logic         misalign;
    logic         range_err;
    logic         zero_word;
    logic         run;

    assign run       = (state_q == F_RUN);
    assign zero_word = HALT_ON_ZERO && (imem_instr == 32'h0000_0000);

    fetch_pc_gen #(
        .RESET_PC   (RESET_PC),
        .IMEM_WORDS (IMEM_WORDS)
    ) u_pc_gen (
        .clk             (clk),
        .reset           (reset),
        .run             (run),
        .stall           (id_stall),
        .halt_req        (zero_word && !range_err),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .pc              (pc),
        .pc_plus4        (pc_plus4),
        .misalign        (misalign),
        .range_err       (range_err)
    );

    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        if_id_d = if_id_p1;
        count_d = count_q;
        unique case (state_q)
            F_RUN: begin
                if (redirect_valid) begin
                    if_id_d.valid = 1'b0;
                    if_id_d.instr = NOP_INSTR;
                    if (misalign) begin
                        state_d = F_FAULT;
                        cause_d = FC_MISALIGN;
                    end
                end else if (!id_stall) begin
                    // Range is tested first: an out-of-range word from ins_mem is meaningless.
                    if (range_err) begin
                        state_d       = F_FAULT;
                        cause_d       = FC_RANGE;
                        if_id_d.valid = 1'b0;
                        if_id_d.instr = NOP_INSTR;
                    end else if (zero_word) begin
                        state_d       = F_HALT;
                        if_id_d.valid = 1'b0;
                        if_id_d.instr = NOP_INSTR;
                    end else begin
                        if_id_d = '{valid: 1'b1, instr: imem_instr, pc: pc, pc_plus4: pc_plus4};
                        count_d = count_q + 32'd1;
                    end
                end
            end
            default: begin
                if_id_d.valid = 1'b0;
                if_id_d.instr = NOP_INSTR;
            end
        endcase
    end

    // IF/ID stage boundary
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= F_RUN;
            cause_q  <= FC_NONE;
            if_id_p1 <= '{valid: 1'b0, instr: NOP_INSTR, pc: 32'h0, pc_plus4: 32'h0};
            count_q  <= 32'h0;
        end else begin
            state_q  <= state_d;
            cause_q  <= cause_d;
            if_id_p1 <= if_id_d;
            count_q  <= count_d;
        end
    end

    assign imem_addr      = pc;
    assign if_id_valid    = if_id_p1.valid;
    assign if_id_instr    = if_id_p1.instr;
    assign if_id_pc       = if_id_p1.pc;
    assign if_id_pc_plus4 = if_id_p1.pc_plus4;
    assign halted         = (state_q == F_HALT);
    assign fault          = (state_q == F_FAULT);
    assign fault_cause    = cause_q;
    assign fetch_count    = count_q;

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Bench for instr_fetch_stage with a behavioural 64-word ins_mem and an IF/ID scoreboard.
module tb_instr_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [96:0] M_ALL = {97{1'b1}};
    localparam logic [96:0] M_VI  = {1'b1, 32'hFFFF_FFFF, 64'h0};

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_target = 32'h0;
    logic        id_stall = 1'b0;
    logic        if_id_valid;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc_plus4;
    logic        halted;
    logic        fault;
    logic [1:0]  fault_cause;
    logic [31:0] fetch_count;

    logic [31:0] mem [0:63];

    typedef struct {
        logic [96:0] val;
        logic [96:0] mask;
        string       name;
    } exp_t;
    exp_t sb[$];
    exp_t e;

    int n_cmp = 0;
    int n_bad = 0;

    logic [96:0] if_id_obs;
    logic [130:0] rst_obs;
    localparam logic [130:0] RST_EXP = {1'b0, NOP, 32'h0, 32'h0, 1'b0, 1'b0, 2'd0, 32'h0};

    assign if_id_obs = {if_id_valid, if_id_instr, if_id_pc, if_id_pc_plus4};
    assign rst_obs   = {if_id_valid, if_id_instr, if_id_pc, if_id_pc_plus4,
                        halted, fault, fault_cause, fetch_count};

    always #5 clk = ~clk;

    always_comb begin
        if (imem_addr < 32'd256) imem_instr = mem[imem_addr[7:2]];
        else                     imem_instr = 32'hDEAD_BEEF;
    end

    instr_fetch_stage #(
        .RESET_PC     (32'h0000_0000),
        .IMEM_WORDS   (64),
        .HALT_ON_ZERO (1'b1)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .imem_addr       (imem_addr),
        .imem_instr      (imem_instr),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .id_stall        (id_stall),
        .if_id_valid     (if_id_valid),
        .if_id_instr     (if_id_instr),
        .if_id_pc        (if_id_pc),
        .if_id_pc_plus4  (if_id_pc_plus4),
        .halted          (halted),
        .fault           (fault),
        .fault_cause     (fault_cause),
        .fetch_count     (fetch_count)
    );

    function automatic logic [96:0] ent(input logic [31:0] instr, input logic [31:0] pc);
        return {1'b1, instr, pc, pc + 32'd4};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_program();
        mem[0] = 32'h0080_0513;  // addi x10,x0,8
        mem[1] = 32'h0095_0593;  // addi x11,x10,9
        mem[2] = 32'h40a5_8633;  // sub  x12,x11,x10
        mem[3] = 32'h0016_4693;  // xori x13,x12,1
        for (int i = 4; i < 64; i++) mem[i] = 32'h0000_0013 | (32'(i) << 20);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        n_cmp++;
        if (rst_obs !== RST_EXP) begin
            n_bad++;
            $display("FAIL reset_state: got %h want %h", rst_obs, RST_EXP);
        end
        n_cmp++;
        if (imem_addr !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_pc: got %h want 00000000", imem_addr);
        end
    endtask

    task automatic test_straight_line();
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            sb.push_back('{ent(mem[k], 32'(k * 4)), M_ALL, "straight"});
            tick();
            e = sb.pop_front();
            n_cmp++;
            if ((if_id_obs & e.mask) !== (e.val & e.mask)) begin
                n_bad++;
                $display("FAIL %s[%0d]: got %h want %h", e.name, k, if_id_obs, e.val);
            end
        end
        n_cmp++;
        if (fetch_count !== 32'd4) begin
            n_bad++;
            $display("FAIL straight_count: got %0d want 4", fetch_count);
        end
    endtask

    task automatic test_redirect();
        for (int k = 4; k < 6; k++) begin
            sb.push_back('{ent(mem[k], 32'(k * 4)), M_ALL, "pre_branch"});
            tick();
            e = sb.pop_front();
            n_cmp++;
            if ((if_id_obs & e.mask) !== (e.val & e.mask)) begin
                n_bad++;
                $display("FAIL %s: got %h want %h", e.name, if_id_obs, e.val);
            end
        end
        redirect_valid = 1'b1;
        redirect_target = 32'h0C;
        sb.push_back('{{1'b0, NOP, 64'h0}, M_VI, "branch_bubble"});
        sb.push_back('{ent(mem[3], 32'h0C), M_ALL, "branch_target"});
        for (int k = 0; k < 2; k++) begin
            tick();
            redirect_valid = 1'b0;
            e = sb.pop_front();
            n_cmp++;
            if ((if_id_obs & e.mask) !== (e.val & e.mask)) begin
                n_bad++;
                $display("FAIL %s: got %h want %h", e.name, if_id_obs, e.val);
            end
        end
        n_cmp++;
        if (fetch_count !== 32'd7) begin
            n_bad++;
            $display("FAIL branch_count: got %0d want 7", fetch_count);
        end
    endtask

    task automatic test_stall_collision();
        id_stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            sb.push_back('{ent(mem[3], 32'h0C), M_ALL, "stall_hold"});
            tick();
            e = sb.pop_front();
            n_cmp++;
            if ((if_id_obs & e.mask) !== (e.val & e.mask) || imem_addr !== 32'h10) begin
                n_bad++;
                $display("FAIL %s: got %h pc %h want %h pc 00000010", e.name, if_id_obs, imem_addr, e.val);
            end
        end
        redirect_valid = 1'b1;
        redirect_target = 32'h20;
        sb.push_back('{{1'b0, NOP, 64'h0}, M_VI, "stall_redirect"});
        tick();
        e = sb.pop_front();
        n_cmp++;
        if ((if_id_obs & e.mask) !== (e.val & e.mask) || imem_addr !== 32'h20) begin
            n_bad++;
            $display("FAIL %s: got %h pc %h want %h pc 00000020", e.name, if_id_obs, imem_addr, e.val);
        end
        redirect_valid = 1'b0;
        id_stall = 1'b0;
        sb.push_back('{ent(mem[8], 32'h20), M_ALL, "after_collision"});
        tick();
        e = sb.pop_front();
        n_cmp++;
        if ((if_id_obs & e.mask) !== (e.val & e.mask) || fetch_count !== 32'd8) begin
            n_bad++;
            $display("FAIL %s: got %h cnt %0d want %h cnt 8", e.name, if_id_obs, fetch_count, e.val);
        end
    endtask

    task automatic test_fault_misalign();
        redirect_valid = 1'b1;
        redirect_target = 32'h22;
        tick();
        n_cmp++;
        if ({fault, fault_cause, halted, imem_addr, if_id_valid, if_id_instr} !==
            {1'b1, 2'd1, 1'b0, 32'h24, 1'b0, NOP}) begin
            n_bad++;
            $display("FAIL misalign: got fault %b cause %0d pc %h vld %b instr %h want 1 1 00000024 0 %h",
                     fault, fault_cause, imem_addr, if_id_valid, if_id_instr, NOP);
        end
        redirect_target = 32'h40;
        tick();
        redirect_valid = 1'b0;
        tick();
        n_cmp++;
        if ({fault, fault_cause, imem_addr, if_id_valid, fetch_count} !==
            {1'b1, 2'd1, 32'h24, 1'b0, 32'd8}) begin
            n_bad++;
            $display("FAIL fault_sticky: got fault %b cause %0d pc %h vld %b cnt %0d want 1 1 00000024 0 8",
                     fault, fault_cause, imem_addr, if_id_valid, fetch_count);
        end
    endtask

    task automatic test_reset_in_fault();
        reset = 1'b1;
        redirect_valid = 1'b1;
        redirect_target = 32'h40;
        id_stall = 1'b1;
        tick();
        n_cmp++;
        if (rst_obs !== RST_EXP || imem_addr !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_from_fault: got %h pc %h want %h pc 00000000", rst_obs, imem_addr, RST_EXP);
        end
        reset = 1'b0;
        redirect_valid = 1'b0;
        id_stall = 1'b0;
        sb.push_back('{ent(mem[0], 32'h0), M_ALL, "first_after_fault_reset"});
        tick();
        e = sb.pop_front();
        n_cmp++;
        if ((if_id_obs & e.mask) !== (e.val & e.mask) || fetch_count !== 32'd1) begin
            n_bad++;
            $display("FAIL %s: got %h cnt %0d want %h cnt 1", e.name, if_id_obs, fetch_count, e.val);
        end
    endtask

    task automatic test_fault_range();
        redirect_valid = 1'b1;
        redirect_target = 32'hF8;
        tick();
        redirect_valid = 1'b0;
        sb.push_back('{ent(mem[62], 32'hF8), M_ALL, "word62"});
        sb.push_back('{ent(mem[63], 32'hFC), M_ALL, "word63"});
        sb.push_back('{{1'b0, NOP, 64'h0}, M_VI, "range_no_load"});
        for (int k = 0; k < 3; k++) begin
            tick();
            e = sb.pop_front();
            n_cmp++;
            if ((if_id_obs & e.mask) !== (e.val & e.mask)) begin
                n_bad++;
                $display("FAIL %s: got %h want %h", e.name, if_id_obs, e.val);
            end
        end
        n_cmp++;
        if ({fault, fault_cause, imem_addr, fetch_count} !== {1'b1, 2'd2, 32'h100, 32'd3}) begin
            n_bad++;
            $display("FAIL range_fault: got fault %b cause %0d pc %h cnt %0d want 1 2 00000100 3",
                     fault, fault_cause, imem_addr, fetch_count);
        end
    endtask

    task automatic test_halt();
        mem[5] = 32'h0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int k = 0; k < 5; k++) sb.push_back('{ent(mem[k], 32'(k * 4)), M_ALL, "pre_halt"});
        sb.push_back('{{1'b0, NOP, 64'h0}, M_VI, "halt_nop"});
        for (int k = 0; k < 6; k++) begin
            tick();
            e = sb.pop_front();
            n_cmp++;
            if ((if_id_obs & e.mask) !== (e.val & e.mask)) begin
                n_bad++;
                $display("FAIL %s[%0d]: got %h want %h", e.name, k, if_id_obs, e.val);
            end
        end
        n_cmp++;
        if ({halted, fault, fetch_count} !== {1'b1, 1'b0, 32'd5}) begin
            n_bad++;
            $display("FAIL halt_state: got halted %b fault %b cnt %0d want 1 0 5", halted, fault, fetch_count);
        end
        redirect_valid = 1'b1;
        redirect_target = 32'h0;
        tick();
        redirect_valid = 1'b0;
        tick();
        n_cmp++;
        if ({halted, if_id_valid, fetch_count} !== {1'b1, 1'b0, 32'd5}) begin
            n_bad++;
            $display("FAIL halt_sticky: got halted %b vld %b cnt %0d want 1 0 5", halted, if_id_valid, fetch_count);
        end
        mem[5] = 32'h0000_0013 | (32'd5 << 20);
    endtask

    task automatic test_reset_in_stall();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        tick();
        id_stall = 1'b1;
        tick();
        reset = 1'b1;
        tick();
        n_cmp++;
        if (rst_obs !== RST_EXP || imem_addr !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_from_stall: got %h pc %h want %h pc 00000000", rst_obs, imem_addr, RST_EXP);
        end
        reset = 1'b0;
        id_stall = 1'b0;
        sb.push_back('{ent(mem[0], 32'h0), M_ALL, "first_after_stall_reset"});
        tick();
        e = sb.pop_front();
        n_cmp++;
        if ((if_id_obs & e.mask) !== (e.val & e.mask) || fetch_count !== 32'd1) begin
            n_bad++;
            $display("FAIL %s: got %h cnt %0d want %h cnt 1", e.name, if_id_obs, fetch_count, e.val);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        load_program();
        test_reset();
        test_straight_line();
        test_redirect();
        test_stall_collision();
        test_fault_misalign();
        test_reset_in_fault();
        test_fault_range();
        test_halt();
        test_reset_in_stall();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
